// File: rtl/inta_sequencer_if.sv
// Signal bundle between the 8259 PIC / CPU core and the INTA acknowledge sequencer.
interface inta_sequencer_if;
  logic       int_req;
  logic       if_en;
  logic [7:0] data_in;
  logic       inta_n;
  logic       lock_n;
  logic [7:0] vec;
  logic       vec_valid;
  logic       vec_ready;
  logic       busy;

  modport master (
    output int_req, if_en, data_in, vec_ready,
    input  inta_n, lock_n, vec, vec_valid, busy
  );

  modport slave (
    input  int_req, if_en, data_in, vec_ready,
    output inta_n, lock_n, vec, vec_valid, busy
  );
endinterface

// File: rtl/inta_sequencer.sv
// CPU-side 8259 acknowledge sequencer: two INTA_n pulses, vector capture, valid/ready delivery.
// Optional bus lock during the pulses is enabled by defining INTA_LOCK_EN.
module inta_sequencer #(
  parameter int unsigned PULSE_W = 2,
  parameter int unsigned GAP_W   = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  inta_sequencer_if.slave bus
);
  localparam int unsigned MAX_W = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
  localparam int unsigned CW    = $clog2(MAX_W) + 1;
  localparam logic [CW-1:0] PULSE_LD = CW'(PULSE_W - 1);
  localparam logic [CW-1:0] GAP_LD   = CW'(GAP_W - 1);

  typedef enum logic [2:0] {
    IDLE,
    PULSE1,
    GAP,
    PULSE2,
    DELIVER
  } state_t;

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic          vec_load;
  logic          inta_n_q, inta_n_d;
  logic          lock_n_q, lock_n_d;
  logic          busy_q, busy_d;
  logic          vec_valid_q, vec_valid_d;
  logic [7:0]    vec_q;

  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    vec_load = 1'b0;
    case (state)
      IDLE: begin
        if (bus.int_req && bus.if_en) begin
          state_d = PULSE1;
          cnt_d   = PULSE_LD;
        end
      end
      PULSE1: begin
        if (cnt == '0) begin
          state_d = GAP;
          cnt_d   = GAP_LD;
        end else begin
          cnt_d = cnt - CW'(1);
        end
      end
      GAP: begin
        if (cnt == '0) begin
          state_d = PULSE2;
          cnt_d   = PULSE_LD;
        end else begin
          cnt_d = cnt - CW'(1);
        end
      end
      PULSE2: begin
        if (cnt == '0) begin
          state_d  = DELIVER;
          cnt_d    = '0;
          vec_load = 1'b1;
        end else begin
          cnt_d = cnt - CW'(1);
        end
      end
      DELIVER: begin
        if (bus.vec_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they are registered yet aligned with it.
  always_comb begin
    inta_n_d    = !((state_d == PULSE1) || (state_d == PULSE2));
    busy_d      = (state_d != IDLE);
    vec_valid_d = (state_d == DELIVER);
`ifdef INTA_LOCK_EN
    lock_n_d    = !((state_d == PULSE1) || (state_d == GAP) || (state_d == PULSE2));
`else
    lock_n_d    = 1'b1;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      inta_n_q    <= 1'b1;
      lock_n_q    <= 1'b1;
      busy_q      <= 1'b0;
      vec_valid_q <= 1'b0;
      vec_q       <= '0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      inta_n_q    <= inta_n_d;
      lock_n_q    <= lock_n_d;
      busy_q      <= busy_d;
      vec_valid_q <= vec_valid_d;
      if (vec_load) begin
        vec_q <= bus.data_in;
      end
    end
  end

  assign bus.inta_n    = inta_n_q;
  assign bus.lock_n    = lock_n_q;
  assign bus.busy      = busy_q;
  assign bus.vec_valid = vec_valid_q;
  assign bus.vec       = vec_q;
endmodule

// File: tb/tb_inta_sequencer.sv
// Self-checking bench for inta_sequencer (PULSE_W=2, GAP_W=2): directed table, corner sequences, random.
module tb_inta_sequencer;
  localparam int PW  = 2;
  localparam int GW  = 2;
  localparam int SEQ = 2 * PW + GW;
`ifdef INTA_LOCK_EN
  localparam bit LOCK_ON = 1'b1;
`else
  localparam bit LOCK_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  inta_sequencer_if bus ();

  inta_sequencer #(.PULSE_W(PW), .GAP_W(GW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference: cycles elapsed since the start was sampled (0 = idle, SEQ+1 = delivering).
  int         pos   = 0;
  logic [7:0] m_vec = 8'h00;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
    end
  endtask

  task automatic compare_model();
    logic e_inta_n, e_lock_n;
    e_inta_n = !((pos >= 1 && pos <= PW) || (pos > PW + GW && pos <= SEQ));
    e_lock_n = LOCK_ON ? !(pos >= 1 && pos <= SEQ) : 1'b1;
    check("model_inta_n",    8'(bus.inta_n),    8'(e_inta_n));
    check("model_lock_n",    8'(bus.lock_n),    8'(e_lock_n));
    check("model_busy",      8'(bus.busy),      8'(pos != 0));
    check("model_vec_valid", 8'(bus.vec_valid), 8'(pos == SEQ + 1));
    check("model_vec",       bus.vec,           m_vec);
  endtask

  // Drive one cycle of inputs, advance the reference on the edge, compare 1ns later.
  task automatic step(input logic r, input logic e, input logic [7:0] d, input logic rd);
    bus.int_req   = r;
    bus.if_en     = e;
    bus.data_in   = d;
    bus.vec_ready = rd;
    @(posedge clk);
    if (!rst_n) begin
      pos   = 0;
      m_vec = 8'h00;
    end else if (pos == 0) begin
      if (r && e) pos = 1;
    end else if (pos < SEQ) begin
      pos++;
    end else if (pos == SEQ) begin
      m_vec = d;
      pos   = SEQ + 1;
    end else if (rd) begin
      pos = 0;
    end
    #1;
    compare_model();
  endtask

  typedef struct {
    logic       req;
    logic       en;
    logic [7:0] data;
    logic       rdy;
    logic       x_inta_n;
    logic       x_busy;
    logic       x_valid;
    logic [7:0] x_vec;
    logic       x_lock_on;
  } row_t;

  row_t tbl[9];

  initial begin
    // Row i = inputs during cycle i (edge i ends it); expectations are for cycle i+1.
    tbl[0] = '{1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0};
    tbl[4] = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0};
    tbl[5] = '{1'b0, 1'b1, 8'h4A, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0};
    tbl[6] = '{1'b0, 1'b1, 8'h4A, 1'b0, 1'b1, 1'b1, 1'b1, 8'h4A, 1'b1};
    tbl[7] = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h4A, 1'b1};
    tbl[8] = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h4A, 1'b1};

    // 1. reset with int_req held high
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 8'h55, 1'b0);
    check("rst_inta_n",    8'(bus.inta_n),    8'h01);
    check("rst_lock_n",    8'(bus.lock_n),    8'h01);
    check("rst_busy",      8'(bus.busy),      8'h00);
    check("rst_vec_valid", 8'(bus.vec_valid), 8'h00);
    check("rst_vec",       bus.vec,           8'h00);
    rst_n = 1'b1;
    step(1'b0, 1'b0, 8'h00, 1'b0);

    // 2. directed single sequence
    for (int i = 0; i < 9; i++) begin
      step(tbl[i].req, tbl[i].en, tbl[i].data, tbl[i].rdy);
      check($sformatf("tbl%0d_inta_n", i), 8'(bus.inta_n),    8'(tbl[i].x_inta_n));
      check($sformatf("tbl%0d_busy", i),   8'(bus.busy),      8'(tbl[i].x_busy));
      check($sformatf("tbl%0d_valid", i),  8'(bus.vec_valid), 8'(tbl[i].x_valid));
      check($sformatf("tbl%0d_vec", i),    bus.vec,           tbl[i].x_vec);
      check($sformatf("tbl%0d_lock_n", i), 8'(bus.lock_n),
            8'(LOCK_ON ? tbl[i].x_lock_on : 1'b1));
    end

    // 3. interrupts disabled
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b0, 8'hFF, 1'b0);
      check("dis_inta_n", 8'(bus.inta_n), 8'h01);
      check("dis_busy",   8'(bus.busy),   8'h00);
    end

    // 4. delayed ready with int_req held; restart only after an idle cycle
    for (int c = 0; c <= 14; c++) begin
      step(1'b1, 1'b1, (c == 5 || c == 6) ? 8'h4A : 8'h11, c == 12);
      if (c >= 6 && c <= 11) begin
        check("hold_valid", 8'(bus.vec_valid), 8'h01);
        check("hold_vec",   bus.vec,           8'h4A);
      end
      if (c >= 6 && c <= 12) check("hold_no_pulse", 8'(bus.inta_n), 8'h01);
      if (c == 12) check("hold_idle_busy", 8'(bus.busy), 8'h00);
      if (c == 13) check("restart_pulse", 8'(bus.inta_n), 8'h00);
    end
    for (int c = 0; c < 8; c++) step(1'b0, 1'b1, 8'h3C, 1'b1);

    // 5a. int_req drops during GAP: sequence completes
    for (int c = 0; c <= 8; c++) begin
      step(c < 3, 1'b1, 8'h91, 1'b0);
      if (c == 6) begin
        check("drop_valid", 8'(bus.vec_valid), 8'h01);
        check("drop_vec",   bus.vec,           8'h91);
      end
    end
    step(1'b0, 1'b0, 8'h00, 1'b1);

    // 5b. reset pulsed during GAP
    for (int c = 0; c < 3; c++) step(1'b1, 1'b1, 8'h00, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_inta_n", 8'(bus.inta_n),    8'h01);
    check("midrst_busy",   8'(bus.busy),      8'h00);
    check("midrst_lock_n", 8'(bus.lock_n),    8'h01);
    check("midrst_vec",    bus.vec,           8'h00);
    step(1'b1, 1'b1, 8'h00, 1'b0);
    rst_n = 1'b1;
    for (int c = 0; c <= 7; c++) begin
      step(1'b1, 1'b1, 8'hC7, c == 7);
      if (c == 0) check("fresh_pulse1", 8'(bus.inta_n), 8'h00);
      if (c == 6) check("fresh_vec", bus.vec, 8'hC7);
    end

    // Random traffic against the reference
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
           8'($urandom), $urandom_range(0, 2) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
